// File: rtl/cpu_lockstep_checker.sv
// Lockstep bus checker: buffers ref/DUV 6502 bus transactions in per-side FIFOs and compares them in order.
// Optional build macro CPU_LOCKSTEP_REG_CMP_EN adds sync + A/X/Y register snapshots to each entry.
module cpu_lockstep_checker #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 16,
    parameter int MAX_SKEW   = 64,
    parameter int CNT_W      = 16,
    parameter int HALT_ON_MM = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              ref_valid,
    input  logic [ADDR_W-1:0] ref_addr,
    input  logic [DATA_W-1:0] ref_data,
    input  logic              ref_rw,
    input  logic              duv_valid,
    input  logic [ADDR_W-1:0] duv_addr,
    input  logic [DATA_W-1:0] duv_data,
    input  logic              duv_rw,
`ifdef CPU_LOCKSTEP_REG_CMP_EN
    input  logic              ref_sync,
    input  logic [DATA_W-1:0] ref_a,
    input  logic [DATA_W-1:0] ref_x,
    input  logic [DATA_W-1:0] ref_y,
    input  logic              duv_sync,
    input  logic [DATA_W-1:0] duv_a,
    input  logic [DATA_W-1:0] duv_x,
    input  logic [DATA_W-1:0] duv_y,
    output logic [ADDR_W+4*DATA_W+1:0] first_ref,
    output logic [ADDR_W+4*DATA_W+1:0] first_duv,
`else
    output logic [ADDR_W+DATA_W:0]     first_ref,
    output logic [ADDR_W+DATA_W:0]     first_duv,
`endif
    output logic [CNT_W-1:0]  match_cnt,
    output logic [CNT_W-1:0]  mm_cnt,
    output logic              mismatch,
    output logic              overflow,
    output logic              timeout,
    output logic [1:0]        state
);

`ifdef CPU_LOCKSTEP_REG_CMP_EN
    localparam int EXT_W = 1 + 3*DATA_W;
`else
    localparam int EXT_W = 0;
`endif
    localparam int BUS_W = ADDR_W + DATA_W + 1;
    localparam int ENT_W = BUS_W + EXT_W;
    localparam int AW    = $clog2(DEPTH);
    localparam int SKW_W = $clog2(MAX_SKEW) + 1;
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ENT_W-1:0] ref_mem [DEPTH];
    logic [ENT_W-1:0] duv_mem [DEPTH];
    logic [AW:0]      ref_wr, ref_rd, duv_wr, duv_rd;
    logic [SKW_W-1:0] skew_cnt;

    logic [ENT_W-1:0] ref_ent, duv_ent, ref_head, duv_head;
    logic ref_empty, duv_empty, ref_full, duv_full;
    logic active, flush, do_cmp, ent_match;
    logic ref_drop, duv_drop, ref_push, duv_push;
    logic ovf_evt, mm_evt, to_evt, one_side;

`ifdef CPU_LOCKSTEP_REG_CMP_EN
    assign ref_ent = {ref_addr, ref_data, ref_rw, ref_sync, ref_a, ref_x, ref_y};
    assign duv_ent = {duv_addr, duv_data, duv_rw, duv_sync, duv_a, duv_x, duv_y};
`else
    assign ref_ent = {ref_addr, ref_data, ref_rw};
    assign duv_ent = {duv_addr, duv_data, duv_rw};
`endif

    assign ref_head  = ref_mem[ref_rd[AW-1:0]];
    assign duv_head  = duv_mem[duv_rd[AW-1:0]];
    assign ref_empty = (ref_wr == ref_rd);
    assign duv_empty = (duv_wr == duv_rd);
    assign ref_full  = (ref_wr[AW] != ref_rd[AW]) && (ref_wr[AW-1:0] == ref_rd[AW-1:0]);
    assign duv_full  = (duv_wr[AW] != duv_rd[AW]) && (duv_wr[AW-1:0] == duv_rd[AW-1:0]);

    // Register snapshots only matter on opcode fetches; sync itself is always compared.
`ifdef CPU_LOCKSTEP_REG_CMP_EN
    assign ent_match = (ref_head[ENT_W-1 -: BUS_W] == duv_head[ENT_W-1 -: BUS_W]) &&
                       (ref_head[3*DATA_W] == duv_head[3*DATA_W]) &&
                       (!ref_head[3*DATA_W] ||
                        (ref_head[3*DATA_W-1:0] == duv_head[3*DATA_W-1:0]));
`else
    assign ent_match = (ref_head == duv_head);
`endif

    assign active   = (state_q == S_RUN) && enable;
    assign flush    = (state_q == S_IDLE) || ((state_q == S_RUN) && !enable);
    assign do_cmp   = active && !ref_empty && !duv_empty;
    // A full FIFO that is popping this clk has room for the incoming entry.
    assign ref_drop = active && ref_valid && ref_full && !do_cmp;
    assign duv_drop = active && duv_valid && duv_full && !do_cmp;
    assign ref_push = active && ref_valid && !ref_drop;
    assign duv_push = active && duv_valid && !duv_drop;
    assign ovf_evt  = ref_drop || duv_drop;
    assign mm_evt   = do_cmp && !ent_match;
    assign one_side = active && (ref_empty != duv_empty);
    assign to_evt   = one_side && (skew_cnt == SKW_W'(MAX_SKEW - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (enable) state_d = S_RUN;
            S_RUN: begin
                if (!enable)
                    state_d = S_IDLE;
                else if (ovf_evt || to_evt || (mm_evt && (HALT_ON_MM != 0)))
                    state_d = S_HALT;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ref_push) ref_mem[ref_wr[AW-1:0]] <= ref_ent;
        if (duv_push) duv_mem[duv_wr[AW-1:0]] <= duv_ent;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ref_wr    <= '0;
            ref_rd    <= '0;
            duv_wr    <= '0;
            duv_rd    <= '0;
            skew_cnt  <= '0;
            match_cnt <= '0;
            mm_cnt    <= '0;
            mismatch  <= 1'b0;
            overflow  <= 1'b0;
            timeout   <= 1'b0;
            first_ref <= '0;
            first_duv <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                ref_wr <= '0;
                ref_rd <= '0;
                duv_wr <= '0;
                duv_rd <= '0;
            end else begin
                if (ref_push) ref_wr <= ref_wr + PTR_ONE;
                if (duv_push) duv_wr <= duv_wr + PTR_ONE;
                if (do_cmp) begin
                    ref_rd <= ref_rd + PTR_ONE;
                    duv_rd <= duv_rd + PTR_ONE;
                end
            end
            skew_cnt <= one_side ? skew_cnt + SKW_W'(1) : '0;
            if (do_cmp && ent_match && (match_cnt != {CNT_W{1'b1}}))
                match_cnt <= match_cnt + CNT_W'(1);
            if (mm_evt && (mm_cnt != {CNT_W{1'b1}}))
                mm_cnt <= mm_cnt + CNT_W'(1);
            if (mm_evt && !mismatch) begin
                first_ref <= ref_head;
                first_duv <= duv_head;
            end
            if (mm_evt)  mismatch <= 1'b1;
            if (ovf_evt) overflow <= 1'b1;
            if (to_evt)  timeout  <= 1'b1;
        end
    end

    assign state = state_q;

endmodule
